// File: rtl/memwb_skid_stage_pkg.sv
// Shared definitions for the MEM/WB skid stage: default widths, the RegWrite bit
// index, and the occupancy/state encoding.
package memwb_skid_stage_pkg;

  localparam int CTRL_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int RW_BIT_DEF = 0;

  typedef enum logic [1:0] {
    STG_EMPTY = 2'd0,
    STG_ONE   = 2'd1,
    STG_FULL  = 2'd2
  } stg_e;

  // The entry valid flags are the state; skid is only ever valid behind main.
  function automatic stg_e stg_decode(input logic main_v, input logic skid_v);
    if (skid_v)      return STG_FULL;
    else if (main_v) return STG_ONE;
    else             return STG_EMPTY;
  endfunction

endpackage

// File: rtl/memwb_skid_stage_if.sv
// MEM/WB handshake bus: upstream valid/ready plus payload, downstream valid/ready
// plus registered payload, forwarding tap and occupancy.
interface memwb_skid_stage_if
  import memwb_skid_stage_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] control;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] alu_result;
  logic [REG_W-1:0]  write_reg;

  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] control_out;
  logic [DATA_W-1:0] read_out;
  logic [DATA_W-1:0] alu_out;
  logic [REG_W-1:0]  write_reg_out;

  logic              fwd_valid;
  logic [1:0]        occupancy;

  // Environment side: drives MEM payload and writeback ready.
  modport master (
    output in_valid, control, read_data, alu_result, write_reg, out_ready,
    input  in_ready, out_valid, control_out, read_out, alu_out, write_reg_out,
           fwd_valid, occupancy
  );

  // Stage side.
  modport slave (
    input  in_valid, control, read_data, alu_result, write_reg, out_ready,
    output in_ready, out_valid, control_out, read_out, alu_out, write_reg_out,
           fwd_valid, occupancy
  );

endinterface

// File: rtl/memwb_skid_stage_entry.sv
// One valid+payload pipeline slot, updated on the falling edge; clear wins over
// load and zeroes the payload so an invalid slot always reads as a NOP.
module pipe_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // NOTE: payload is reset along with the flag because downstream reads it as a bubble when invalid.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      // NOTE: non-blocking so every slot samples pre-edge values, keeping main<-skid moves race-free.
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline register with valid/ready handshake and a 2-entry skid buffer,
// stage enable (power), flush (wipe) and a MEM/WB forwarding tap.
module memwb_skid_stage
  import memwb_skid_stage_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int RW_BIT = RW_BIT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wipe,
  input  logic                power,
  memwb_skid_stage_if.slave   bus
);

  localparam int PAY_W = CTRL_W + 2 * DATA_W + REG_W;

  logic             main_valid, skid_valid;
  logic [PAY_W-1:0] main_q, skid_q, main_d, in_pay;
  logic             main_load, main_clear, main_from_skid;
  logic             skid_load, skid_clear;
  logic             push, pop;
  stg_e             state;

  assign in_pay = {bus.control, bus.read_data, bus.alu_result, bus.write_reg};
  assign main_d = main_from_skid ? skid_q : in_pay;
  assign state  = stg_decode(main_valid, skid_valid);

  assign bus.in_ready  = !reset && power && !skid_valid;
  assign bus.out_valid = !reset && power && main_valid;
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // NOTE: every control is defaulted first so no path through the case infers a latch.
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (wipe) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (power) begin
      unique case (state)
        STG_EMPTY: main_load = push;
        STG_ONE: begin
          if (push && pop)  main_load  = 1'b1;
          else if (push)    skid_load  = 1'b1;
          else if (pop)     main_clear = 1'b1;
        end
        STG_FULL: begin
          // in_ready is low here, so only the pop can happen.
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  pipe_entry_reg #(.W(PAY_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .clear (main_clear),
    .load  (main_load),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  pipe_entry_reg #(.W(PAY_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (skid_clear),
    .load  (skid_load),
    .d     (in_pay),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign bus.control_out   = main_q[PAY_W-1 -: CTRL_W];
  assign bus.read_out      = main_q[REG_W+DATA_W +: DATA_W];
  assign bus.alu_out       = main_q[REG_W +: DATA_W];
  assign bus.write_reg_out = main_q[REG_W-1:0];
  assign bus.occupancy     = state;

  assign bus.fwd_valid = bus.out_valid && bus.control_out[RW_BIT] &&
                         (bus.write_reg_out != '0);

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Directed bench for memwb_skid_stage: reset/bubble, streaming, back-pressure,
// wipe, freeze and forwarding-gate scenarios with hand-computed expectations.
module tb_memwb_skid_stage;

  logic clk = 1'b1;
  logic reset, wipe, power;
  int   total = 0;
  int   bad   = 0;

  memwb_skid_stage_if #(.CTRL_W(8), .DATA_W(32), .REG_W(5)) bus ();

  memwb_skid_stage dut (
    .clk   (clk),
    .reset (reset),
    .wipe  (wipe),
    .power (power),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance past the next (active) falling edge; outputs are then stable.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [7:0] c, input logic [4:0] wr,
                       input logic [31:0] alu);
    bus.in_valid   = v;
    bus.control    = c;
    bus.write_reg  = wr;
    bus.alu_result = alu;
    bus.read_data  = ~alu;
  endtask

  task automatic test_reset();
    power = 1'b1;
    bus.out_ready = 1'b0;
    offer(1'b1, 8'h00, 5'd0, 32'h1234);
    step();
    offer(1'b0, 8'h00, 5'd0, 32'h0);
    total++;
    if (bus.alu_out !== 32'h1234) begin
      bad++; $display("FAIL reset_preload alu_out got %h want %h", bus.alu_out, 32'h1234);
    end
    #3 reset = 1'b1;
    #1;
    total++;
    if ({bus.control_out, bus.read_out, bus.alu_out, bus.write_reg_out} !== '0) begin
      bad++; $display("FAIL reset_payload got %h/%h/%h/%h want 0", bus.control_out,
                      bus.read_out, bus.alu_out, bus.write_reg_out);
    end
    total++;
    if (bus.occupancy !== 2'd0) begin
      bad++; $display("FAIL reset_occ got %0d want 0", bus.occupancy);
    end
    total++;
    if ({bus.in_ready, bus.out_valid, bus.fwd_valid} !== 3'b000) begin
      bad++; $display("FAIL reset_flags in_ready/out_valid/fwd got %b want 000",
                      {bus.in_ready, bus.out_valid, bus.fwd_valid});
    end
    reset = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_streaming();
    bus.out_ready = 1'b1;
    offer(1'b1, 8'h01, 5'd3, 32'hA5A5_0001);
    step();
    total++;
    if ({bus.out_valid, bus.fwd_valid} !== 2'b11 || bus.alu_out !== 32'hA5A5_0001) begin
      bad++; $display("FAIL stream_first out_valid=%b fwd=%b alu_out=%h want 1 1 a5a50001",
                      bus.out_valid, bus.fwd_valid, bus.alu_out);
    end
    for (int i = 2; i <= 4; i++) begin
      offer(1'b1, 8'h01, 5'd3, 32'hA5A5_0000 + 32'(i));
      step();
      total++;
      if (bus.alu_out !== 32'hA5A5_0000 + 32'(i) || bus.occupancy !== 2'd1) begin
        bad++; $display("FAIL stream_b2b[%0d] alu_out=%h occ=%0d want %h 1", i, bus.alu_out,
                        bus.occupancy, 32'hA5A5_0000 + 32'(i));
      end
    end
    offer(1'b0, 8'h00, 5'd0, 32'h0);
    step();
    total++;
    if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.alu_out !== 32'h0 ||
        bus.control_out !== 8'h00) begin
      bad++; $display("FAIL stream_drain occ=%0d out_valid=%b alu_out=%h ctrl=%h want 0 0 0 0",
                      bus.occupancy, bus.out_valid, bus.alu_out, bus.control_out);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] expect_q[$];
    bus.out_ready = 1'b0;
    offer(1'b1, 8'h01, 5'd4, 32'd1); step();
    offer(1'b1, 8'h01, 5'd4, 32'd2); step();
    total++;
    if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_full occ=%0d in_ready=%b want 2 0", bus.occupancy, bus.in_ready);
    end
    offer(1'b1, 8'h01, 5'd4, 32'd3); step();
    total++;
    if (bus.occupancy !== 2'd2 || bus.alu_out !== 32'd1) begin
      bad++; $display("FAIL bp_holdoff occ=%0d alu_out=%h want 2 1", bus.occupancy, bus.alu_out);
    end
    expect_q = '{32'd2, 32'd3};
    bus.out_ready = 1'b1;
    foreach (expect_q[k]) begin
      step();
      if (k == 1) offer(1'b0, 8'h00, 5'd0, 32'h0);
      total++;
      if (bus.alu_out !== expect_q[k] || bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_order[%0d] alu_out=%h out_valid=%b want %h 1", k,
                        bus.alu_out, bus.out_valid, expect_q[k]);
      end
    end
    step();
    total++;
    if (bus.occupancy !== 2'd0) begin
      bad++; $display("FAIL bp_empty occ=%0d want 0", bus.occupancy);
    end
  endtask

  task automatic test_wipe();
    bus.out_ready = 1'b0;
    offer(1'b1, 8'h01, 5'd5, 32'd10); step();
    offer(1'b1, 8'h01, 5'd5, 32'd11); step();
    total++;
    if (bus.occupancy !== 2'd2) begin
      bad++; $display("FAIL wipe_fill occ=%0d want 2", bus.occupancy);
    end
    wipe = 1'b1;
    offer(1'b1, 8'h01, 5'd6, 32'd12);
    bus.out_ready = 1'b1;
    step();
    total++;
    if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0 ||
        {bus.control_out, bus.read_out, bus.alu_out, bus.write_reg_out} !== '0) begin
      bad++; $display("FAIL wipe_clear occ=%0d out_valid=%b alu_out=%h ctrl=%h wr=%0d want all 0",
                      bus.occupancy, bus.out_valid, bus.alu_out, bus.control_out,
                      bus.write_reg_out);
    end
    wipe = 1'b0;
    offer(1'b0, 8'h00, 5'd0, 32'h0);
    step();
    total++;
    if (bus.occupancy !== 2'd0 || bus.alu_out !== 32'h0) begin
      bad++; $display("FAIL wipe_dropped occ=%0d alu_out=%h want 0 0", bus.occupancy, bus.alu_out);
    end
  endtask

  task automatic test_freeze();
    bus.out_ready = 1'b0;
    offer(1'b1, 8'h01, 5'd2, 32'h55); step();
    offer(1'b0, 8'h00, 5'd0, 32'h0);
    power = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(1'(i % 2 == 0), 8'hFF, 5'(i + 9), 32'hDEAD_0000 + 32'(i));
      bus.out_ready = 1'(i % 2);
      step();
      total++;
      if (bus.alu_out !== 32'h55 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
          bus.occupancy !== 2'd1) begin
        bad++; $display("FAIL freeze[%0d] alu_out=%h out_valid=%b in_ready=%b occ=%0d want 55 0 0 1",
                        i, bus.alu_out, bus.out_valid, bus.in_ready, bus.occupancy);
      end
    end
    offer(1'b0, 8'h00, 5'd0, 32'h0);
    bus.out_ready = 1'b0;
    power = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.alu_out !== 32'h55 || bus.write_reg_out !== 5'd2) begin
      bad++; $display("FAIL freeze_resume out_valid=%b alu_out=%h wr=%0d want 1 55 2",
                      bus.out_valid, bus.alu_out, bus.write_reg_out);
    end
    bus.out_ready = 1'b1;
    step();
    total++;
    if (bus.occupancy !== 2'd0) begin
      bad++; $display("FAIL freeze_drain occ=%0d want 0", bus.occupancy);
    end
  endtask

  task automatic test_forwarding();
    bus.out_ready = 1'b0;
    offer(1'b1, 8'h01, 5'd0, 32'h77); step();
    total++;
    if (bus.fwd_valid !== 1'b0 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL fwd_r0 fwd_valid=%b out_valid=%b want 0 1", bus.fwd_valid, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    offer(1'b1, 8'h01, 5'd7, 32'h77); step();
    total++;
    if (bus.fwd_valid !== 1'b1 || bus.write_reg_out !== 5'd7) begin
      bad++; $display("FAIL fwd_r7 fwd_valid=%b wr=%0d want 1 7", bus.fwd_valid, bus.write_reg_out);
    end
    offer(1'b1, 8'h02, 5'd7, 32'h78); step();
    total++;
    if (bus.fwd_valid !== 1'b0 || bus.control_out !== 8'h02) begin
      bad++; $display("FAIL fwd_norw fwd_valid=%b ctrl=%h want 0 02", bus.fwd_valid, bus.control_out);
    end
    offer(1'b0, 8'h00, 5'd0, 32'h0); step();
    total++;
    if (bus.fwd_valid !== 1'b0 || bus.occupancy !== 2'd0) begin
      bad++; $display("FAIL fwd_bubble fwd_valid=%b occ=%0d want 0 0", bus.fwd_valid, bus.occupancy);
    end
  endtask

  initial begin
    reset = 1'b1;
    wipe  = 1'b0;
    power = 1'b1;
    bus.out_ready = 1'b0;
    offer(1'b0, 8'h00, 5'd0, 32'h0);
    step();
    step();
    reset = 1'b0;
    #2;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_wipe();
    test_freeze();
    test_forwarding();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memwb_skid_stage.md
Name: memwb_skid_stage

Overview:
- Parametrised MEM/WB pipeline register for the next pipeline revision.
- Adds a valid/ready handshake with a 2-entry skid buffer, so writeback can back-pressure without losing a MEM result.
- Keeps the existing power (stage enable) and wipe (flush) semantics, and adds a forwarding tap for the hazard unit.
- Sits between the data-memory stage and register-file writeback.

Parameters:
- CTRL_W, 8: control bundle width.
- DATA_W, 32: width of the memory read data and the ALU result.
- REG_W, 5: destination register index width.
- RW_BIT, 0: index of the RegWrite bit inside the control bundle. Must be < CTRL_W.

Ports:
- clk  in  1  stage clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- wipe  in  1  synchronous flush; sampled on the falling edge.
- power  in  1  stage enable; 0 freezes the stage.
- in_valid  in  1  MEM stage presents an entry.
- in_ready  out  1  stage can accept an entry.
- control  in  CTRL_W  control bundle.
- read_data  in  DATA_W  memory read data.
- alu_result  in  DATA_W  ALU result.
- write_reg  in  REG_W  destination register.
- out_valid  out  1  output entry valid.
- out_ready  in  1  writeback consumes the entry.
- control_out  out  CTRL_W  registered control bundle.
- read_out  out  DATA_W  registered read data.
- alu_out  out  DATA_W  registered ALU result.
- write_reg_out  out  REG_W  registered destination register.
- fwd_valid  out  1  forwarding tap is live.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Storage: main entry drives the outputs; skid entry holds one overflow entry. Each entry has a valid flag.
- State encoding: EMPTY (main invalid), ONE (main valid, skid invalid), FULL (both valid).
- occupancy is 0/1/2 for EMPTY/ONE/FULL.
- Handshake:
  - in_ready = power & !skid_valid.
  - out_valid = power & main_valid.
  - push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated at the falling edge.
- Transitions (power=1, wipe=0):
  - EMPTY + push -> ONE; main loads the inputs.
  - EMPTY, no push -> stays EMPTY.
  - ONE + push + pop -> ONE; main loads the inputs.
  - ONE + push, no pop -> FULL; skid loads the inputs, main holds.
  - ONE + pop, no push -> EMPTY.
  - ONE, neither -> holds.
  - FULL + pop -> ONE; main loads the skid, skid invalidates. No push is possible because in_ready=0.
  - FULL, no pop -> holds.
- Bubble rule: whenever main is invalid, control_out, read_out, alu_out and write_reg_out are all 0. A bubble is therefore a NOP with RegWrite=0.
- wipe=1 on a falling edge: both entries invalidated and all payload outputs zeroed. wipe has priority over power and over push/pop; an entry offered in that cycle is dropped.
- power=0 (with wipe=0): no state or payload change. in_ready and out_valid read 0, so no transfers are counted. Held data reappears when power returns to 1.
- reset=1 asserts asynchronously, mid-cycle or mid-transfer:
  - all valid flags and payload registers go to 0;
  - state goes to EMPTY and occupancy to 0;
  - in_ready, out_valid and fwd_valid read 0.
  - After release, the first falling edge follows the normal rules.
- fwd_valid = out_valid & control_out[RW_BIT] & (write_reg_out != 0). Purely combinational from registered state, for the hazard unit's MEM/WB forwarding compare.
- Latency: an entry pushed into EMPTY appears on the outputs after the same falling edge (1 stage). An entry parked in the skid appears on the falling edge that pops its predecessor.
- Ordering: strict FIFO; no entry is duplicated or lost except by wipe or reset.

Decomposition:
- Shared pipeline package holds:
  - the state encoding constants STG_EMPTY=2'd0, STG_ONE=2'd1, STG_FULL=2'd2;
  - the default widths CTRL_W/DATA_W/REG_W;
  - the RegWrite bit index constant.
- One sub-module is natural: pipe_entry_reg, a single valid+payload register with load/clear. Instantiate it twice (main, skid).

Test Plan:
- Reset/bubble: assert reset mid-cycle with main holding alu_result=32'h1234 -> all outputs 0 immediately, occupancy=0, in_ready=0 while reset is high; in_ready=1 once reset is low and power=1.
- Streaming: out_ready=1, push control=8'h01, write_reg=5'd3, alu_result=32'hA5A5_0001 -> next falling edge: out_valid=1, alu_out=32'hA5A5_0001, fwd_valid=1; occupancy stays 1 under back-to-back pushes.
- Back-pressure: out_ready=0, push values 1, 2, 3 on consecutive edges -> after 2 pushes occupancy=2 and in_ready=0; value 3 is held off. Raise out_ready -> outputs 1 then 2 then 3 in order, none lost.
- Wipe: in FULL state assert wipe while in_valid=1 -> next edge occupancy=0, all payload outputs 0, offered entry dropped.
- Freeze: in ONE state with alu_out=32'h55, drop power for 3 edges while toggling inputs -> outputs unchanged, out_valid=0, in_ready=0; restore power -> out_valid=1 with alu_out=32'h55.
- Forwarding gate: entry with control[RW_BIT]=1 and write_reg=0 -> fwd_valid=0; same entry with write_reg=5'd7 -> fwd_valid=1.
